// File: rtl/zero_elim_encoder.sv
// zero_elim_encoder: streams the non-zero lanes of a dense brick one per beat with their lane offset.
// Define ZE_STATS_EN to add saturating zero-lane and brick counters.
module zero_elim_encoder #(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_ELEMS = 16,
    parameter int SEL_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [NUM_ELEMS*BIT_WIDTH-1:0] i_brick,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [BIT_WIDTH-1:0]           o_value,
    output logic [SEL_WIDTH-1:0]           o_offset,
    output logic                           o_last,
    output logic                           o_zero_brick
`ifdef ZE_STATS_EN
    ,
    output logic [31:0]                    o_zero_count,
    output logic [31:0]                    o_brick_count
`endif
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state, state_nxt;
    logic [NUM_ELEMS*BIT_WIDTH-1:0] brick;
    logic [NUM_ELEMS-1:0] mask, in_mask, mask_rest;
    logic [SEL_WIDTH-1:0] low_idx;
    logic accept, beat;
    always_comb begin
        in_mask = '0;
        for (int k = 0; k < NUM_ELEMS; k++) in_mask[k] = |i_brick[k*BIT_WIDTH +: BIT_WIDTH];
    end
    // Descending scan so the lowest set lane wins.
    always_comb begin
        low_idx = '0;
        for (int k = NUM_ELEMS - 1; k >= 0; k--) if (mask[k]) low_idx = SEL_WIDTH'(k);
    end
    assign mask_rest    = mask & (mask - NUM_ELEMS'(1));
    assign o_ready      = state == IDLE;
    assign o_valid      = state == EMIT;
    assign o_offset     = low_idx;
    assign o_value      = o_valid ? brick[low_idx*BIT_WIDTH +: BIT_WIDTH] : '0;
    assign o_last       = o_valid && mask_rest == '0;
    assign o_zero_brick = o_valid && mask == '0;
    assign accept       = o_ready && i_valid;
    assign beat         = o_valid && i_ready;
    always_comb begin
        state_nxt = state;
        state_nxt = accept ? EMIT : state_nxt;
        state_nxt = (beat && o_last) ? IDLE : state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brick <= '0;
            mask  <= '0;
        end else if (accept) begin
            brick <= i_brick;
            mask  <= in_mask;
        end else if (beat) begin
            mask <= mask_rest;
        end
    end
`ifdef ZE_STATS_EN
    logic [SEL_WIDTH:0] zeros;
    logic [32:0] zero_sum;
    always_comb begin
        zeros = '0;
        for (int k = 0; k < NUM_ELEMS; k++) zeros = zeros + (SEL_WIDTH+1)'(!in_mask[k]);
    end
    assign zero_sum = {1'b0, o_zero_count} + 33'(zeros);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_zero_count  <= '0;
            o_brick_count <= '0;
        end else if (accept) begin
            o_zero_count  <= zero_sum[32] ? '1 : zero_sum[31:0];
            o_brick_count <= (&o_brick_count) ? o_brick_count : o_brick_count + 32'd1;
        end
    end
`endif
endmodule
